manchester_unescape: RTL and testbench

- Receive-side inverse of the transmit escaper.
- Consumes the escaped byte stream recovered after Manchester decoding and byte alignment, and restores the original payload:
  - ESCAPE,START_WORD becomes ESCAPED_SYMBOL, flagged as start of frame.
  - ESCAPE,ESCAPE becomes a single ESCAPE.
- Illegal escape sequences are flagged and counted.
- Sits between the byte aligner (upstream) and the packet consumer (downstream). AXI-Stream on both sides.

---
 rtl/manchester_unescape.sv | 119 +++++++++++
 tb/tb_manchester_unescape.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_unescape.sv
// Receive-side unescaper: restores payload bytes from the escaped stream,
// flags start of frame and counts illegal escape sequences.
module manchester_unescape #(
    parameter int unsigned              DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0]    ESCAPE_SYMBOL  = 8'hE5,
    parameter logic [DATA_WIDTH-1:0]    START_WORD     = 8'hF5,
    parameter logic [DATA_WIDTH-1:0]    ESCAPED_SYMBOL = 8'hD5,
    parameter int unsigned              ERR_CNT_WIDTH  = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic {S_DATA, S_ESC} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    user_q, user_d;
    logic                    vld_q, vld_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    acc;

    assign s_axis_tready = !vld_q || m_axis_tready;
    assign acc           = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        user_d  = user_q;
        // A taken beat empties the stage unless refilled below.
        vld_d   = vld_q && !m_axis_tready;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (acc) begin
            unique case (state_q)
                S_DATA: begin
                    if (s_axis_tdata == ESCAPE_SYMBOL) begin
                        if (s_axis_tlast) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_ESC;
                        end
                    end else begin
                        vld_d  = 1'b1;
                        data_d = s_axis_tdata;
                        last_d = s_axis_tlast;
                        user_d = 1'b0;
                    end
                end
                S_ESC: begin
                    state_d = S_DATA;
                    vld_d   = 1'b1;
                    last_d  = s_axis_tlast;
                    unique case (1'b1)
                        s_axis_tdata == ESCAPE_SYMBOL: begin
                            data_d = ESCAPE_SYMBOL;
                            user_d = 1'b0;
                        end
                        s_axis_tdata == START_WORD: begin
                            data_d = ESCAPED_SYMBOL;
                            user_d = 1'b1;
                        end
                        default: begin
                            data_d = s_axis_tdata;
                            user_d = 1'b0;
                            err_d  = 1'b1;
                        end
                    endcase
                end
                default: state_d = S_DATA;
            endcase
        end
        if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_DATA;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign err_pulse     = err_q;
    assign err_count     = cnt_q;

endmodule

// File: tb/tb_manchester_unescape.sv
// Table-driven bench for manchester_unescape with an output scoreboard.
module tb_manchester_unescape;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic       s_tlast = 1'b0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tlast;
    logic       m_tuser;
    logic       err_pulse;
    logic [1:0] err_count;

    manchester_unescape #(.ERR_CNT_WIDTH(2)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .err_pulse     (err_pulse),
        .err_count     (err_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       o;
        logic [7:0] ed;
        logic       el;
        logic       eu;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nout = 0;
    int   bp_mode = 0;
    int   bp_idx = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic l, input logic o,
                       input logic [7:0] ed, input logic el,
                       input logic eu, input logic ee);
        vec_t v;
        v.d = d; v.l = l; v.o = o;
        v.ed = ed; v.el = el; v.eu = eu; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic send(input vec_t v);
        int  n;
        bit  ok;
        exp_t e;
        s_tvalid = 1'b1;
        s_tdata  = v.d;
        s_tlast  = v.l;
        n  = 0;
        ok = 1'b0;
        while (n < 100) begin
            @(negedge aclk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready stuck low, data %0h", v.d);
            s_tvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        if (v.o) begin
            e.d = v.ed; e.l = v.el; e.u = v.eu;
            q.push_back(e);
        end
        chk("err_pulse", {31'd0, err_pulse}, {31'd0, v.ee});
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) send(tbl[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("scoreboard_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        q.delete();
        tbl.delete();
    endtask

    // Sink ready pattern: always ready, or 1,0,0,1 repeating.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (bp_mode != 0) begin
                m_tready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
                bp_idx++;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // Output monitor: pops on each beat taken at the coming edge.
    initial begin
        bit         stall;
        logic [7:0] hd;
        logic       hl, hu;
        exp_t       e;
        stall = 1'b0;
        hd = '0; hl = 1'b0; hu = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 1'b0;
                continue;
            end
            chk("tready_rule", {31'd0, s_tready},
                {31'd0, (!m_tvalid || m_tready)});
            if (stall && m_tvalid) begin
                chk("stall_data", {23'd0, m_tdata, hl, hu},
                    {23'd0, hd, m_tlast, m_tuser});
                chk("stall_hold", {30'd0, m_tlast, m_tuser}, {30'd0, hl, hu});
            end
            stall = m_tvalid && !m_tready;
            hd = m_tdata; hl = m_tlast; hu = m_tuser;
            if (m_tvalid && m_tready) begin
                nout++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             m_tdata);
                end else begin
                    e = q.pop_front();
                    chk("out_beat", {22'd0, m_tdata, m_tlast, m_tuser},
                        {22'd0, e.d, e.l, e.u});
                end
            end
        end
    end

    task automatic load_nominal();
        tbl.delete();
        add(8'hE5, 0, 0, 8'h00, 0, 0, 0);
        add(8'hF5, 0, 1, 8'hD5, 0, 1, 0);
        add(8'h11, 0, 1, 8'h11, 0, 0, 0);
        add(8'h22, 0, 1, 8'h22, 0, 0, 0);
        add(8'h33, 0, 1, 8'h33, 0, 0, 0);
        add(8'hE5, 0, 0, 8'h00, 0, 0, 0);
        add(8'hE5, 1, 1, 8'hE5, 1, 0, 0);
        add(8'h44, 0, 1, 8'h44, 0, 0, 0);
    endtask

    initial begin
        int base;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 0);
        chk("rst_tdata", {24'd0, m_tdata}, 0);
        chk("rst_tlast_tuser", {30'd0, m_tlast, m_tuser}, 0);
        chk("rst_err", {29'd0, err_pulse, err_count}, 0);
        aresetn = 1'b1;

        // Nominal frame
        do_reset();
        load_nominal();
        base = nout;
        run_tbl();
        drain();
        chk("nominal_count", nout - base, 6);
        chk("nominal_errcnt", {30'd0, err_count}, 0);

        // Same frame under back-pressure
        do_reset();
        bp_idx = 0;
        bp_mode = 1;
        load_nominal();
        base = nout;
        run_tbl();
        drain();
        bp_mode = 0;
        chk("bp_count", nout - base, 6);
        chk("bp_errcnt", {30'd0, err_count}, 0);

        // Illegal escape
        do_reset();
        add(8'hE5, 0, 0, 8'h00, 0, 0, 0);
        add(8'h37, 0, 1, 8'h37, 0, 0, 1);
        add(8'h55, 0, 1, 8'h55, 0, 0, 0);
        base = nout;
        run_tbl();
        drain();
        chk("illegal_count", nout - base, 2);
        chk("illegal_errcnt", {30'd0, err_count}, 1);

        // ESCAPE carrying tlast
        do_reset();
        add(8'h11, 0, 1, 8'h11, 0, 0, 0);
        add(8'hE5, 1, 0, 8'h00, 0, 0, 1);
        add(8'h22, 0, 1, 8'h22, 0, 0, 0);
        base = nout;
        run_tbl();
        drain();
        chk("esclast_count", nout - base, 2);
        chk("esclast_errcnt", {30'd0, err_count}, 1);

        // Split pair with idle gap
        do_reset();
        add(8'hE5, 0, 0, 8'h00, 0, 0, 0);
        add(8'hF5, 1, 1, 8'hD5, 1, 1, 0);
        base = nout;
        send(tbl[0]);
        repeat (5) @(posedge aclk);
        #1;
        send(tbl[1]);
        drain();
        chk("split_count", nout - base, 1);
        chk("split_errcnt", {30'd0, err_count}, 0);

        // Saturation, then reset while in ESC
        do_reset();
        for (int i = 0; i < 5; i++) begin
            add(8'hE5, 0, 0, 8'h00, 0, 0, 0);
            add(8'h00, 0, 1, 8'h00, 0, 0, 1);
        end
        add(8'h77, 1, 1, 8'h77, 1, 0, 0);
        add(8'hE5, 0, 0, 8'h00, 0, 0, 0);
        run_tbl();
        drain();
        chk("sat_errcnt", {30'd0, err_count}, 3);
        chk("pre_rst_tdata", {24'd0, m_tdata}, 32'h77);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", {31'd0, m_tvalid}, 0);
        chk("mid_rst_tdata", {24'd0, m_tdata}, 0);
        chk("mid_rst_tlast_tuser", {30'd0, m_tlast, m_tuser}, 0);
        chk("mid_rst_err", {29'd0, err_pulse, err_count}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        q.delete();
        tbl.delete();
        add(8'hF5, 0, 1, 8'hF5, 0, 0, 0);
        base = nout;
        run_tbl();
        drain();
        chk("post_rst_count", nout - base, 1);
        chk("post_rst_errcnt", {30'd0, err_count}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
